// File: rtl/shift_pkg.sv
// Shared mode encoding for the universal shift register.
package shift_pkg;

   localparam int SHIFT_MODE_W = 3;

   typedef enum logic [SHIFT_MODE_W-1:0] {
      HOLD = 3'd0,
      SHL  = 3'd1,
      SHR  = 3'd2,
      ROL  = 3'd3,
      ROR  = 3'd4,
      LOAD = 3'd5
   } shift_mode_t;

endpackage

// File: rtl/shift_frame_counter.sv
// Counts serial operations and pulses done when WIDTH of them complete a word.
// Latency: done is registered, high the cycle after the wrapping step. No backpressure.
module shift_frame_counter
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic step,
   output logic done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            cnt <= '0;
         end else if (step) begin
            if (cnt == LAST) begin
               cnt  <= '0;
               done <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/shift_reg_nbit.sv
// Universal shift register: hold/shift/rotate/load with registered serial out and frame pulse.
// Latency: all outputs one cycle after the sampling edge. No backpressure; en=0 stalls everything.
module shift_reg_nbit
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [SHIFT_MODE_W-1:0] mode,
   input  logic                    ser_in,
   input  logic [WIDTH-1:0]        par_in,
   output logic [WIDTH-1:0]        par_out,
   output logic                    ser_out,
   output logic                    frame_done
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_nxt;
   logic             so;
   logic             so_nxt;
   logic             is_shift;
   logic             is_load;

   // Reserved codes fall into the default arm and therefore behave as HOLD.
   always_comb begin
      q_nxt    = q;
      so_nxt   = so;
      is_shift = 1'b0;
      is_load  = 1'b0;
      case (shift_mode_t'(mode))
         SHL: begin
            q_nxt    = {q[WIDTH-2:0], ser_in};
            so_nxt   = q[WIDTH-1];
            is_shift = 1'b1;
         end
         SHR: begin
            q_nxt    = {ser_in, q[WIDTH-1:1]};
            so_nxt   = q[0];
            is_shift = 1'b1;
         end
         ROL: begin
            q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
            so_nxt   = q[WIDTH-1];
            is_shift = 1'b1;
         end
         ROR: begin
            q_nxt    = {q[0], q[WIDTH-1:1]};
            so_nxt   = q[0];
            is_shift = 1'b1;
         end
         LOAD: begin
            q_nxt   = par_in;
            so_nxt  = 1'b0;
            is_load = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q  <= '0;
         so <= 1'b0;
      end else if (en) begin
         q  <= q_nxt;
         so <= so_nxt;
      end
   end

   shift_frame_counter #(
      .WIDTH (WIDTH)
   ) u_frame_counter (
      .clk   (clk),
      .reset (reset),
      .clear (en & is_load),
      .step  (en & is_shift),
      .done  (frame_done)
   );

   assign par_out = q;
   assign ser_out = so;

endmodule

// File: tb/tb_shift_reg_nbit.sv
// Drives a 4-bit and an 8-bit instance with shared stimulus and checks both against an arithmetic model.
module tb_shift_reg_nbit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [2:0] mode = 3'd0;
   logic       ser_in = 1'b0;
   logic [7:0] par_in = 8'h00;

   logic [3:0] po4;
   logic       so4;
   logic       fd4;
   logic [7:0] po8;
   logic       so8;
   logic       fd8;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state per instance: index 0 is WIDTH=4, index 1 is WIDTH=8.
   logic [7:0] mq[2];
   logic       mso[2];
   int         mcnt[2];
   logic       mfd[2];

   always #5 clk = ~clk;

   shift_reg_nbit #(.WIDTH(4)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .ser_in     (ser_in),
      .par_in     (par_in[3:0]),
      .par_out    (po4),
      .ser_out    (so4),
      .frame_done (fd4)
   );

   shift_reg_nbit #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .ser_in     (ser_in),
      .par_in     (par_in),
      .par_out    (po8),
      .ser_out    (so8),
      .frame_done (fd8)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: register as an integer word, counter as a count of serial ops modulo w.
   task automatic model(input int i);
      int         w;
      logic [7:0] mask;
      logic [7:0] q;
      logic       msb;
      logic       lsb;
      logic       sh;
      w    = (i == 0) ? 4 : 8;
      mask = 8'((1 << w) - 1);
      q    = mq[i];
      msb  = q[w-1];
      lsb  = q[0];
      sh   = 1'b0;
      if (reset) begin
         mq[i] = 8'h00; mso[i] = 1'b0; mcnt[i] = 0; mfd[i] = 1'b0;
      end else begin
         mfd[i] = 1'b0;
         if (en) begin
            case (mode)
               3'd1: begin mso[i] = msb; q = ((q << 1) | {7'b0, ser_in}) & mask; sh = 1'b1; end
               3'd2: begin mso[i] = lsb; q = (q >> 1) | ({7'b0, ser_in} << (w - 1)); sh = 1'b1; end
               3'd3: begin mso[i] = msb; q = ((q << 1) | {7'b0, msb}) & mask; sh = 1'b1; end
               3'd4: begin mso[i] = lsb; q = (q >> 1) | ({7'b0, lsb} << (w - 1)); sh = 1'b1; end
               3'd5: begin mso[i] = 1'b0; q = par_in & mask; mcnt[i] = 0; end
               default: begin end
            endcase
            if (sh) begin
               mcnt[i]++;
               if (mcnt[i] == w) begin
                  mcnt[i] = 0;
                  mfd[i]  = 1'b1;
               end
            end
            mq[i] = q;
         end
      end
   endtask

   task automatic check_all();
      chk("par_out4", {4'b0, po4}, mq[0]);
      chk("ser_out4", {7'b0, so4}, {7'b0, mso[0]});
      chk("frame4",   {7'b0, fd4}, {7'b0, mfd[0]});
      chk("par_out8", po8, mq[1]);
      chk("ser_out8", {7'b0, so8}, {7'b0, mso[1]});
      chk("frame8",   {7'b0, fd8}, {7'b0, mfd[1]});
   endtask

   // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic cyc(input logic r, input logic e, input logic [2:0] m, input logic s,
                      input logic [7:0] p);
      @(negedge clk);
      reset = r; en = e; mode = m; ser_in = s; par_in = p;
      @(posedge clk);
      model(0);
      model(1);
      #1;
      check_all();
   endtask

   initial begin
      logic [7:0] a5;
      logic [3:0] sv_po;
      logic       sv_so;
      logic [3:0] shr_exp;
      logic [3:0] fill;

      for (int i = 0; i < 2; i++) begin
         mq[i] = 8'hxx; mso[i] = 1'bx; mcnt[i] = 0; mfd[i] = 1'bx;
      end

      // Reset
      cyc(1, 0, 3'd0, 0, 8'h00);
      cyc(1, 1, 3'd1, 1, 8'hFF);
      chk("reset_par4", {4'b0, po4}, 8'h00);
      chk("reset_fd4",  {7'b0, fd4}, 8'h00);

      // 1. Serial fill 1,1,0,1
      fill = 4'b1011;
      for (int k = 0; k < 4; k++) begin
         cyc(0, 1, 3'd1, fill[k], 8'h00);
         if (k < 3) chk("fill_fd_early", {7'b0, fd4}, 8'h00);
      end
      chk("fill_par", {4'b0, po4}, 8'h0D);
      chk("fill_fd",  {7'b0, fd4}, 8'h01);
      chk("fill_so",  {7'b0, so4}, 8'h00);
      cyc(0, 0, 3'd1, 1, 8'h00);
      chk("fill_fd_drop", {7'b0, fd4}, 8'h00);

      // 2. Rotate left
      cyc(0, 1, 3'd3, 0, 8'h00);
      chk("rol_par", {4'b0, po4}, 8'h0B);
      chk("rol_so",  {7'b0, so4}, 8'h01);
      for (int k = 0; k < 3; k++) cyc(0, 1, 3'd3, 0, 8'h00);
      chk("rol4_par", {4'b0, po4}, 8'h0D);
      chk("rol4_fd",  {7'b0, fd4}, 8'h01);

      // 3. Shift right with a 2-cycle stall
      cyc(0, 1, 3'd5, 0, 8'h00);
      shr_exp = 4'b0000;
      for (int k = 0; k < 6; k++) begin
         if (k == 2 || k == 3) begin
            cyc(0, 0, 3'd2, 0, 8'h00);
            chk("shr_stall_fd", {7'b0, fd4}, 8'h00);
         end else begin
            cyc(0, 1, 3'd2, 1, 8'h00);
            shr_exp = {1'b1, shr_exp[3:1]};
         end
         chk("shr_par", {4'b0, po4}, {4'b0, shr_exp});
      end
      chk("shr_fd", {7'b0, fd4}, 8'h01);

      // 4. Load and serialise on the 8-bit instance
      a5 = 8'hA5;
      cyc(0, 1, 3'd5, 0, a5);
      chk("load_par8", po8, 8'hA5);
      chk("load_so8",  {7'b0, so8}, 8'h00);
      for (int k = 0; k < 8; k++) begin
         cyc(0, 1, 3'd1, 0, 8'h00);
         chk("ser_seq8", {7'b0, so8}, {7'b0, a5[7-k]});
         if (k < 7) chk("ser_fd8_early", {7'b0, fd8}, 8'h00);
      end
      chk("ser_par8", po8, 8'h00);
      chk("ser_fd8",  {7'b0, fd8}, 8'h01);

      // 5. Reset mid-frame
      cyc(0, 1, 3'd1, 1, 8'h00);
      cyc(0, 1, 3'd1, 1, 8'h00);
      cyc(1, 1, 3'd1, 1, 8'h00);
      chk("rst_par4", {4'b0, po4}, 8'h00);
      chk("rst_so4",  {7'b0, so4}, 8'h00);
      chk("rst_fd4",  {7'b0, fd4}, 8'h00);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 1, 3'd1, 1, 8'h00);
         chk("rst_refill_fd4", {7'b0, fd4}, (k == 3) ? 8'h01 : 8'h00);
      end

      // 6. Reserved modes
      cyc(0, 1, 3'd2, 0, 8'h00);
      sv_po = po4;
      sv_so = so4;
      cyc(0, 1, 3'd6, 1, 8'hFF);
      chk("rsv6_par", {4'b0, po4}, {4'b0, sv_po});
      chk("rsv6_so",  {7'b0, so4}, {7'b0, sv_so});
      chk("rsv6_fd",  {7'b0, fd4}, 8'h00);
      cyc(0, 1, 3'd7, 0, 8'hFF);
      chk("rsv7_par", {4'b0, po4}, {4'b0, sv_po});
      chk("rsv7_fd",  {7'b0, fd4}, 8'h00);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_reg_nbit.md
# shift_reg_nbit

Parametrised universal shift register: the successor to the fixed 4-bit serial-in shifter. It adds configurable width, six operating modes (hold, shift left/right, rotate left/right, parallel load), a registered serial output and a frame counter. The frame counter pulses once for every WIDTH serial shifts, so a downstream consumer can capture `par_out` as a complete deserialised word. It sits between a bit-serial source and word-wide logic, and can also serialise a parallel word.

## Interface
- `WIDTH`, default 8: register width in bits. Legal range is 2 or more.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `en`  input  1  operation enable. When 0, the register, counter and `ser_out` hold.
- `mode`  input  3  operation select, encoded as `shift_mode_t`.
- `ser_in`  input  1  serial data input.
- `par_in`  input  WIDTH  parallel load data.
- `par_out`  output  WIDTH  register contents, driven directly from the register.
- `ser_out`  output  1  registered copy of the bit most recently shifted or rotated out.
- `frame_done`  output  1  one-cycle pulse marking completion of WIDTH serial operations.

## Operation
Mode encoding (`shift_mode_t`):
- 0 `HOLD`
- 1 `SHL`
- 2 `SHR`
- 3 `ROL`
- 4 `ROR`
- 5 `LOAD`
- 6 and 7 are reserved and behave exactly as `HOLD`.

Per-mode behaviour, with q = `par_out`, at each rising edge when `en`=1 and `reset`=0:
- `SHL`: q ← {q[W-2:0], `ser_in`}; `ser_out` ← q[W-1].
- `SHR`: q ← {`ser_in`, q[W-1:1]}; `ser_out` ← q[0].
- `ROL`: q ← {q[W-2:0], q[W-1]}; `ser_out` ← q[W-1].
- `ROR`: q ← {q[0], q[W-1:1]}; `ser_out` ← q[0].
- `LOAD`: q ← `par_in`; `ser_out` ← 0; frame counter ← 0.
- `HOLD` and reserved codes: q, `ser_out` and the counter are unchanged.

Frame counter:
- Width is $clog2(WIDTH). It counts `SHL`/`SHR`/`ROL`/`ROR` operations performed with `en`=1.
- An operation performed while count = WIDTH-1 wraps the count to 0 and sets `frame_done`=1 for the following cycle.
- `frame_done` is 0 in every other cycle, including cycles with `en`=0.
- Mode changes between shift types do not reset the count. Only `LOAD` and `reset` clear it.

Reset:
- With `reset`=1 at a rising edge: `par_out`=0, `ser_out`=0, `frame_done`=0, counter=0.
- `reset` has priority over `en` and `mode`.
- Reset mid-frame discards the partial count; a full WIDTH operations are then required before the next `frame_done`.

## Timing
- All outputs are registered. Every update is visible one cycle after the rising edge that samples the inputs.
- Inputs are sampled only at the rising edge of `clk`. The bench drives inputs on the falling edge.
- `frame_done` asserts in the same cycle that `par_out` first shows the completed word. It is high for exactly one cycle.
- Back-to-back frames produce `frame_done` every WIDTH enabled shift cycles, with no dead cycle.
- `en` may toggle freely; disabled cycles stretch the frame without corrupting it.

## Structure
- Package `shift_pkg` holds:
  - `shift_mode_t`, a 3-bit enum with the six named values above;
  - the constant `SHIFT_MODE_W = 3`.
- Sub-module `shift_frame_counter` (parameter `WIDTH`; ports `clk`, `reset`, `clear`, `step`, `done`) implements the wrap counter and the `frame_done` register.
- The top level contains the mode decode, the data register and the `ser_out` register.

## Test plan
Scenarios 1–3 use WIDTH=4; scenario 4 uses WIDTH=8.
1. **Serial fill.** Reset, then `SHL` with `ser_in` = 1,1,0,1. Required: `par_out`=4'b1101; `frame_done` high only in the cycle after the 4th shift; `ser_out`=0.
2. **Rotate left.** From 4'b1101, one `ROL`. Required: `par_out`=4'b1011 and `ser_out`=1. Three more `ROL` return `par_out` to 4'b1101, with `frame_done` pulsing after the 4th.
3. **Shift right and enable.** `SHR` with `ser_in`=1 from 4'b0000, with `en` deasserted for 2 cycles mid-stream. Required: the sequence 1000, 1100, 1110, 1111 is unaffected by the stall; `frame_done` fires once.
4. **Load and serialise.** `LOAD` 8'hA5, then 8 `SHL` with `ser_in`=0. Required: `ser_out` sequence 1,0,1,0,0,1,0,1; final `par_out`=8'h00; `frame_done` after the 8th shift; the counter was cleared by `LOAD`.
5. **Reset mid-frame.** 2 shifts, then `reset` for 1 cycle with `en`=1 and `mode`=`SHL`. Required: all outputs 0. The next `frame_done` comes only after 4 further shifts.
6. **Reserved modes.** Drive `mode`=6 and then 7 with `en`=1. Required: `par_out`, `ser_out` and the counter are unchanged, and `frame_done` stays 0.
